// File: rtl/fact_engine.sv
//------------------------------------------------------------------------------
// Module   : fact_engine
// Brief    : Iterative n! engine; control FSM and multiply/decrement datapath.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fact_engine #(
  parameter int N_WIDTH   = 4,
  parameter int RES_WIDTH = 32,
  parameter int MAX_N     = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 go,
  input  logic [N_WIDTH-1:0]   n,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [RES_WIDTH-1:0] result,
  output logic [2:0]           state
);

  localparam logic [2:0] c_idle  = 3'd0;
  localparam logic [2:0] c_check = 3'd1;
  localparam logic [2:0] c_err   = 3'd2;
  localparam logic [2:0] c_test  = 3'd3;
  localparam logic [2:0] c_mult  = 3'd4;
  localparam logic [2:0] c_done  = 3'd5;

  localparam int         c_pw    = RES_WIDTH + N_WIDTH;
  localparam logic [31:0] c_max  = MAX_N;

  logic [2:0]           r_state;
  logic [N_WIDTH-1:0]   r_n;
  logic [N_WIDTH-1:0]   r_cnt;
  logic [RES_WIDTH-1:0] r_acc;
  logic [RES_WIDTH-1:0] r_result;

  logic [c_pw-1:0]      w_prod;
  logic                 w_ovf;
  logic                 w_range_err;

  // Full-width product so any carry out of the accumulator is visible.
  assign w_prod      = {{N_WIDTH{1'b0}}, r_acc} * {{RES_WIDTH{1'b0}}, r_cnt};
  assign w_ovf       = |w_prod[c_pw-1:RES_WIDTH];
  assign w_range_err = {{(32-N_WIDTH){1'b0}}, r_n} > c_max;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= c_idle;
      r_n      <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (go) begin
            r_n      <= n;
            r_result <= '0;
            r_state  <= c_check;
          end
        end
        c_check: begin
          if (w_range_err) begin
            r_state <= c_err;
          end else begin
            r_cnt   <= r_n;
            r_acc   <= RES_WIDTH'(1);
            r_state <= c_test;
          end
        end
        c_test: begin
          if (r_cnt > N_WIDTH'(1)) begin
            r_state <= c_mult;
          end else begin
            r_result <= r_acc;
            r_state  <= c_done;
          end
        end
        c_mult: begin
          if (w_ovf) begin
            r_state <= c_err;
          end else begin
            r_acc   <= w_prod[RES_WIDTH-1:0];
            r_cnt   <= r_cnt - N_WIDTH'(1);
            r_state <= c_test;
          end
        end
        c_done: r_state <= c_idle;
        c_err: begin
          r_result <= '0;
          r_state  <= c_idle;
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  // Status outputs come from the state register alone.
  assign busy   = (r_state != c_idle);
  assign done   = (r_state == c_done);
  assign error  = (r_state == c_err);
  assign result = r_result;
  assign state  = r_state;

endmodule

`default_nettype wire

// File: tb/tb_fact_engine.sv
//------------------------------------------------------------------------------
// Module   : tb_fact_engine
// Brief    : Directed-vector bench for fact_engine (default and 16-bit builds).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fact_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        go, go16;
  logic [3:0]  n_in, n16;
  logic        busy, done, error;
  logic [31:0] result;
  logic [2:0]  state;
  logic        busy16, done16, error16;
  logic [15:0] result16;
  logic [2:0]  state16;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fact_engine u_dut (
    .clk    (clk),
    .reset  (reset),
    .go     (go),
    .n      (n_in),
    .busy   (busy),
    .done   (done),
    .error  (error),
    .result (result),
    .state  (state)
  );

  fact_engine #(.N_WIDTH(4), .RES_WIDTH(16), .MAX_N(15)) u_dut16 (
    .clk    (clk),
    .reset  (reset),
    .go     (go16),
    .n      (n16),
    .busy   (busy16),
    .done   (done16),
    .error  (error16),
    .result (result16),
    .state  (state16)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse go, then count edges until done or error; lat is the edge index.
  task automatic run(input bit sel, input logic [3:0] v, input bit noisy,
                     output int lat, output bit got_done);
    logic d, e;
    @(negedge clk);
    if (sel) begin go16 = 1'b1; n16 = v; end
    else     begin go   = 1'b1; n_in = v; end
    @(posedge clk);
    @(negedge clk);
    go = 1'b0; go16 = 1'b0;
    chk("busy_after_go", sel ? busy16 : busy, 1);
    lat = -1;
    got_done = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (noisy && k < 8) begin go = k[0]; n_in = 4'd3; end
      else if (noisy) go = 1'b0;
      @(posedge clk);
      @(negedge clk);
      d = sel ? done16 : done;
      e = sel ? error16 : error;
      if (d | e) begin
        lat = k;
        got_done = d;
        chk("done_err_excl", d & e, 0);
        break;
      end
    end
    if (lat < 0) chk("timeout", 1, 0);
  endtask

  int lat;
  bit gd;
  bit hit;

  initial begin
    reset = 1'b1; go = 1'b0; go16 = 1'b0; n_in = '0; n16 = '0;
    repeat (2) @(negedge clk);
    chk("rst_state",  state, 0);
    chk("rst_result", result, 0);
    chk("rst_busy",   busy, 0);
    chk("rst_done",   done, 0);
    chk("rst_error",  error, 0);
    reset = 1'b0;

    run(0, 4'd5, 0, lat, gd);
    chk("n5_lat", lat, 10); chk("n5_done", gd, 1);
    chk("n5_result", result, 120); chk("n5_state", state, 5);

    run(0, 4'd0, 0, lat, gd);
    chk("n0_lat", lat, 2); chk("n0_result", result, 1);
    run(0, 4'd1, 0, lat, gd);
    chk("n1_lat", lat, 2); chk("n1_result", result, 1);

    run(0, 4'd12, 0, lat, gd);
    chk("n12_lat", lat, 24); chk("n12_done", gd, 1);
    chk("n12_result", result, 479001600);

    run(0, 4'd13, 0, lat, gd);
    chk("n13_lat", lat, 1); chk("n13_is_err", gd, 0);
    chk("n13_result", result, 0); chk("n13_state", state, 2);
    @(negedge clk);
    chk("n13_idle", state, 0);
    chk("n13_err_fall", error, 0);

    run(1, 4'd9, 0, lat, gd);
    chk("w16_n9_is_err", gd, 0); chk("w16_n9_result", result16, 0);
    run(1, 4'd8, 0, lat, gd);
    chk("w16_n8_lat", lat, 16); chk("w16_n8_done", gd, 1);
    chk("w16_n8_result", result16, 40320);

    run(0, 4'd6, 1, lat, gd);
    chk("n6_noisy_lat", lat, 12); chk("n6_noisy_result", result, 720);
    run(0, 4'd4, 0, lat, gd);
    chk("back2back_lat", lat, 8); chk("back2back_result", result, 24);

    // Abort a long run from inside MULT.
    @(negedge clk);
    go = 1'b1; n_in = 4'd10;
    @(negedge clk);
    go = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (state == 3'd4) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    chk("reach_mult", hit, 1);
    #2 reset = 1'b1;
    #1;
    chk("abort_state",  state, 0);
    chk("abort_result", result, 0);
    chk("abort_busy",   busy, 0);
    chk("abort_done",   done, 0);
    chk("abort_error",  error, 0);
    @(negedge clk);
    reset = 1'b0;
    run(0, 4'd4, 0, lat, gd);
    chk("post_abort_lat", lat, 8); chk("post_abort_result", result, 24);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
